instruction_decode: RTL and testbench

- Second pipeline stage of the RV32I core.
- Consumes the registered instruction and PC from the fetch stage, reads the 32x32 integer register file, and decodes control signals and the immediate.
- Registers everything into the ID/EX pipeline register for the execute stage.
- Detects load-use hazards and stalls the fetch stage.
- Owns the register file write port driven by writeback.

---
 rtl/instruction_decode_pkg.sv | 81 ++++++++
 rtl/instruction_decode_register_file.sv | 37 +++
 rtl/instruction_decode.sv | 209 ++++++++++++++++++++
 tb/tb_instruction_decode.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pkg.sv
// Shared RV32I decode definitions: ALU operations, writeback selects,
// base opcodes and the ID/EX pipeline payload.
package riscv_definitions;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // All-zero encodes a NOP bubble: ADD, no write, no memory, no control flow.
  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [2:0] funct3;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       illegal;
    wb_sel_e    wb_sel;
  } id_ex_ctrl_s;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    id_ex_ctrl_s ctrl;
  } id_ex_s;

  // ALU operation for OP / OP-IMM. Only register ops use funct7[5] to pick
  // SUB; both use it to pick SRA over SRL.
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3,
                                            input logic       funct7_b5,
                                            input logic       is_reg_op);
    alu_op_e op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = (is_reg_op && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 integer register file: two combinational read ports with
// write-through bypass, one write port, x0 hardwired to zero.
module register_file #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  logic [31:0] r_regs [NUM_REGS];

  // Write port; reset clears every register regardless of clk_en.
  // NOTE: this array is reset explicitly because the core relies on all
  // registers reading 0 after reset; that forces flops rather than RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (clk_en && wb_en && (wb_rd != 5'd0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // x0 reads zero; a same-cycle writeback to the read register is forwarded.
  assign rs1_data = (rs1 == 5'd0)                 ? 32'd0   :
                    (wb_en && (wb_rd == rs1))     ? wb_data : r_regs[rs1];
  assign rs2_data = (rs2 == 5'd0)                 ? 32'd0   :
                    (wb_en && (wb_rd == rs2))     ? wb_data : r_regs[rs2];

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: register read, control/immediate decode, load-use
// hazard detection and the ID/EX pipeline register.
module instruction_decode
  import riscv_definitions::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        flush,
  input  logic [31:0] inst_id,
  input  logic [31:0] pc_id,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] pc_ex,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [4:0]  rs1_ex,
  output logic [4:0]  rs2_ex,
  output logic [4:0]  rd_ex,
  output logic [31:0] imm_ex,
  output logic [3:0]  alu_op_ex,
  output logic        alu_a_sel_ex,
  output logic        alu_b_sel_ex,
  output logic [2:0]  funct3_ex,
  output logic        mem_read_ex,
  output logic        mem_write_ex,
  output logic        reg_write_ex,
  output logic        branch_ex,
  output logic        jump_ex,
  output logic        illegal_ex,
  output logic [1:0]  wb_sel_ex
);

  id_ex_s      r_ex;
  id_ex_s      w_next;
  id_ex_ctrl_s w_ctrl;
  logic [31:0] w_imm;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [6:0]  w_opcode;

  assign w_opcode = inst_id[6:0];
  assign w_rs1    = w_use_rs1 ? inst_id[19:15] : 5'd0;
  assign w_rs2    = w_use_rs2 ? inst_id[24:20] : 5'd0;

  register_file #(.NUM_REGS(NUM_REGS)) u_register_file (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .rs1      (w_rs1),
    .rs2      (w_rs2),
    .rs1_data (w_rs1_data),
    .rs2_data (w_rs2_data),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (w_wb_data_unused_guard(wb_data))
  );

  function automatic logic [31:0] w_wb_data_unused_guard(input logic [31:0] d);
    return d;
  endfunction

  // Decode control fields, operand usage and the sign-extended immediate.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    w_ctrl    = '0;
    w_imm     = '0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_ctrl.alu_op    = alu_op_decode(inst_id[14:12], inst_id[30], 1'b1);
        w_ctrl.reg_write = 1'b1;
        w_use_rs1        = 1'b1;
        w_use_rs2        = 1'b1;
      end
      OPC_OP_IMM: begin
        w_ctrl.alu_op    = alu_op_decode(inst_id[14:12], inst_id[30], 1'b0);
        w_ctrl.alu_b_sel = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_use_rs1        = 1'b1;
        w_imm            = {{20{inst_id[31]}}, inst_id[31:20]};
      end
      OPC_LOAD: begin
        w_ctrl.alu_b_sel = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel    = WB_MEM;
        w_use_rs1        = 1'b1;
        w_imm            = {{20{inst_id[31]}}, inst_id[31:20]};
      end
      OPC_STORE: begin
        w_ctrl.alu_b_sel = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_use_rs1        = 1'b1;
        w_use_rs2        = 1'b1;
        w_imm            = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
      end
      OPC_BRANCH: begin
        w_ctrl.alu_op = ALU_SUB;
        w_ctrl.branch = 1'b1;
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
        w_imm         = {{20{inst_id[31]}}, inst_id[7], inst_id[30:25],
                         inst_id[11:8], 1'b0};
      end
      OPC_JAL: begin
        w_ctrl.alu_a_sel = 1'b1;
        w_ctrl.alu_b_sel = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel    = WB_PC4;
        w_imm            = {{12{inst_id[31]}}, inst_id[19:12], inst_id[20],
                            inst_id[30:21], 1'b0};
      end
      OPC_JALR: begin
        w_ctrl.alu_b_sel = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel    = WB_PC4;
        w_use_rs1        = 1'b1;
        w_imm            = {{20{inst_id[31]}}, inst_id[31:20]};
      end
      OPC_LUI: begin
        w_ctrl.alu_op    = ALU_PASS_B;
        w_ctrl.alu_b_sel = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_imm            = {inst_id[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        w_ctrl.alu_a_sel = 1'b1;
        w_ctrl.alu_b_sel = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_imm            = {inst_id[31:12], 12'd0};
      end
      default: begin
        w_ctrl.illegal = 1'b1;
      end
    endcase
    // Compressed/reserved encodings share the illegal path.
    if (inst_id[1:0] != 2'b11) begin
      w_ctrl         = '0;
      w_ctrl.illegal = 1'b1;
      w_imm          = '0;
      w_use_rs1      = 1'b0;
      w_use_rs2      = 1'b0;
    end
    if (!w_ctrl.illegal) w_ctrl.funct3 = inst_id[14:12];
  end

  // Assemble the next ID/EX payload; an all-zero instruction is a bubble.
  always_comb begin
    w_next          = '0;
    w_next.pc       = pc_id;
    w_next.rs1_data = w_rs1_data;
    w_next.rs2_data = w_rs2_data;
    w_next.rs1      = w_rs1;
    w_next.rs2      = w_rs2;
    w_next.rd       = w_ctrl.reg_write ? inst_id[11:7] : 5'd0;
    w_next.imm      = w_imm;
    w_next.ctrl     = w_ctrl;
    if (inst_id == 32'd0) w_next = '0;
  end

  // Load-use hazard against the load now in EX; a flush overrides it.
  assign stall = !flush && r_ex.ctrl.mem_read && (r_ex.rd != 5'd0) &&
                 ((w_use_rs1 && (r_ex.rd == inst_id[19:15])) ||
                  (w_use_rs2 && (r_ex.rd == inst_id[24:20])));

  // ID/EX register: rst > flush > stall > normal update.
  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex <= '0;
    end else if (clk_en) begin
      if (flush || stall) r_ex <= '0;
      else                r_ex <= w_next;
    end
  end

  assign pc_ex        = r_ex.pc;
  assign rs1_data_ex  = r_ex.rs1_data;
  assign rs2_data_ex  = r_ex.rs2_data;
  assign rs1_ex       = r_ex.rs1;
  assign rs2_ex       = r_ex.rs2;
  assign rd_ex        = r_ex.rd;
  assign imm_ex       = r_ex.imm;
  assign alu_op_ex    = r_ex.ctrl.alu_op;
  assign alu_a_sel_ex = r_ex.ctrl.alu_a_sel;
  assign alu_b_sel_ex = r_ex.ctrl.alu_b_sel;
  assign funct3_ex    = r_ex.ctrl.funct3;
  assign mem_read_ex  = r_ex.ctrl.mem_read;
  assign mem_write_ex = r_ex.ctrl.mem_write;
  assign reg_write_ex = r_ex.ctrl.reg_write;
  assign branch_ex    = r_ex.ctrl.branch;
  assign jump_ex      = r_ex.ctrl.jump;
  assign illegal_ex   = r_ex.ctrl.illegal;
  assign wb_sel_ex    = r_ex.ctrl.wb_sel;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for the RV32I decode stage.
module tb_instruction_decode;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        flush;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] pc_ex;
  logic [31:0] rs1_data_ex;
  logic [31:0] rs2_data_ex;
  logic [4:0]  rs1_ex;
  logic [4:0]  rs2_ex;
  logic [4:0]  rd_ex;
  logic [31:0] imm_ex;
  logic [3:0]  alu_op_ex;
  logic        alu_a_sel_ex;
  logic        alu_b_sel_ex;
  logic [2:0]  funct3_ex;
  logic        mem_read_ex;
  logic        mem_write_ex;
  logic        reg_write_ex;
  logic        branch_ex;
  logic        jump_ex;
  logic        illegal_ex;
  logic [1:0]  wb_sel_ex;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
  localparam logic [31:0] LW_X2_X1    = 32'h0000_A103;
  localparam logic [31:0] ADD_X3_X2   = 32'h0021_01B3;
  localparam logic [31:0] ADD_X6_X5   = 32'h0002_8333;
  localparam logic [31:0] ADD_X7_X0   = 32'h0000_03B3;
  localparam logic [31:0] ADD_X7_0_X5 = 32'h0050_03B3;
  localparam logic [31:0] BEQ_M4      = 32'hFE00_0EE3;
  localparam logic [31:0] JAL_X1_8    = 32'h0080_00EF;
  localparam logic [31:0] LUI_X5      = 32'h1234_52B7;
  localparam logic [31:0] SW_X2_4_X1  = 32'h0020_A223;
  localparam logic [31:0] ADDI_X4_X1  = 32'h0000_8213;

  instruction_decode #(.NUM_REGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .flush        (flush),
    .inst_id      (inst_id),
    .pc_id        (pc_id),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall        (stall),
    .pc_ex        (pc_ex),
    .rs1_data_ex  (rs1_data_ex),
    .rs2_data_ex  (rs2_data_ex),
    .rs1_ex       (rs1_ex),
    .rs2_ex       (rs2_ex),
    .rd_ex        (rd_ex),
    .imm_ex       (imm_ex),
    .alu_op_ex    (alu_op_ex),
    .alu_a_sel_ex (alu_a_sel_ex),
    .alu_b_sel_ex (alu_b_sel_ex),
    .funct3_ex    (funct3_ex),
    .mem_read_ex  (mem_read_ex),
    .mem_write_ex (mem_write_ex),
    .reg_write_ex (reg_write_ex),
    .branch_ex    (branch_ex),
    .jump_ex      (jump_ex),
    .illegal_ex   (illegal_ex),
    .wb_sel_ex    (wb_sel_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    clk_en  = 1'b0;
    flush   = 1'b0;
    inst_id = 32'd0;
    pc_id   = 32'd0;
    wb_en   = 1'b0;
    wb_rd   = 5'd0;
    wb_data = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_pc_ex", pc_ex, 32'd0);
    check("rst_rd_ex", {27'd0, rd_ex}, 32'd0);
    check("rst_reg_write", {31'd0, reg_write_ex}, 32'd0);
    check("rst_imm_ex", imm_ex, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // addi x1,x0,5 while writeback loads x1=5
    clk_en  = 1'b1;
    inst_id = ADDI_X1_5;
    pc_id   = 32'h0000_0100;
    wb_en   = 1'b1;
    wb_rd   = 5'd1;
    wb_data = 32'd5;
    #1;
    check("addi_stall", {31'd0, stall}, 32'd0);
    tick();
    check("addi_rd", {27'd0, rd_ex}, 32'd1);
    check("addi_imm", imm_ex, 32'd5);
    check("addi_alu_op", {28'd0, alu_op_ex}, 32'd0);
    check("addi_b_sel", {31'd0, alu_b_sel_ex}, 32'd1);
    check("addi_reg_write", {31'd0, reg_write_ex}, 32'd1);
    check("addi_pc", pc_ex, 32'h0000_0100);

    // lw x2,0(x1): reads x1=5
    wb_en   = 1'b0;
    inst_id = LW_X2_X1;
    pc_id   = 32'h0000_0104;
    #1;
    check("lw_stall", {31'd0, stall}, 32'd0);
    tick();
    check("lw_mem_read", {31'd0, mem_read_ex}, 32'd1);
    check("lw_rd", {27'd0, rd_ex}, 32'd2);
    check("lw_wb_sel", {30'd0, wb_sel_ex}, 32'd1);
    check("lw_rs1_data", rs1_data_ex, 32'd5);
    check("lw_funct3", {29'd0, funct3_ex}, 32'd2);

    // add x3,x2,x2: one-cycle load-use stall, then issue
    inst_id = ADD_X3_X2;
    pc_id   = 32'h0000_0108;
    #1;
    check("lu_stall_on", {31'd0, stall}, 32'd1);
    tick();
    check("lu_bubble_rw", {31'd0, reg_write_ex}, 32'd0);
    check("lu_bubble_mr", {31'd0, mem_read_ex}, 32'd0);
    check("lu_bubble_pc", pc_ex, 32'd0);
    check("lu_stall_off", {31'd0, stall}, 32'd0);
    tick();
    check("add_rs1", {27'd0, rs1_ex}, 32'd2);
    check("add_rs2", {27'd0, rs2_ex}, 32'd2);
    check("add_rd", {27'd0, rd_ex}, 32'd3);
    check("add_b_sel", {31'd0, alu_b_sel_ex}, 32'd0);
    check("add_pc", pc_ex, 32'h0000_0108);

    // Bypass: write x5 in the same cycle as add x6,x5,x0
    inst_id = ADD_X6_X5;
    pc_id   = 32'h0000_010C;
    wb_en   = 1'b1;
    wb_rd   = 5'd5;
    wb_data = 32'hDEAD_BEEF;
    tick();
    check("byp_rs1_data", rs1_data_ex, 32'hDEAD_BEEF);
    check("byp_rs2_data", rs2_data_ex, 32'd0);
    check("byp_rd", {27'd0, rd_ex}, 32'd6);

    // Write to x0 is ignored, including through the bypass
    inst_id = ADD_X7_X0;
    wb_rd   = 5'd0;
    wb_data = 32'hFFFF_FFFF;
    tick();
    check("x0_bypass", rs1_data_ex, 32'd0);
    wb_en   = 1'b0;
    inst_id = ADD_X7_0_X5;
    tick();
    check("x0_read", rs1_data_ex, 32'd0);
    check("x5_stored", rs2_data_ex, 32'hDEAD_BEEF);

    // beq x0,x0,-4
    inst_id = BEQ_M4;
    pc_id   = 32'h0000_0110;
    tick();
    check("beq_imm", imm_ex, 32'hFFFF_FFFC);
    check("beq_branch", {31'd0, branch_ex}, 32'd1);
    check("beq_alu_op", {28'd0, alu_op_ex}, 32'd1);
    check("beq_reg_write", {31'd0, reg_write_ex}, 32'd0);
    check("beq_rd", {27'd0, rd_ex}, 32'd0);
    check("beq_illegal", {31'd0, illegal_ex}, 32'd0);

    // jal x1,8
    inst_id = JAL_X1_8;
    tick();
    check("jal_imm", imm_ex, 32'd8);
    check("jal_jump", {31'd0, jump_ex}, 32'd1);
    check("jal_wb_sel", {30'd0, wb_sel_ex}, 32'd2);
    check("jal_a_sel", {31'd0, alu_a_sel_ex}, 32'd1);
    check("jal_rd", {27'd0, rd_ex}, 32'd1);

    // lui x5,0x12345
    inst_id = LUI_X5;
    tick();
    check("lui_imm", imm_ex, 32'h1234_5000);
    check("lui_alu_op", {28'd0, alu_op_ex}, 32'd10);
    check("lui_rd", {27'd0, rd_ex}, 32'd5);

    // sw x2,4(x1)
    inst_id = SW_X2_4_X1;
    tick();
    check("sw_imm", imm_ex, 32'd4);
    check("sw_mem_write", {31'd0, mem_write_ex}, 32'd1);
    check("sw_reg_write", {31'd0, reg_write_ex}, 32'd0);
    check("sw_rd", {27'd0, rd_ex}, 32'd0);

    // Flush during a load-use stall
    inst_id = LW_X2_X1;
    tick();
    inst_id = ADD_X3_X2;
    pc_id   = 32'h0000_0200;
    #1;
    check("fl_pre_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    check("fl_stall_masked", {31'd0, stall}, 32'd0);
    tick();
    check("fl_bubble_rw", {31'd0, reg_write_ex}, 32'd0);
    check("fl_bubble_mr", {31'd0, mem_read_ex}, 32'd0);
    check("fl_bubble_pc", pc_ex, 32'd0);
    flush = 1'b0;

    // Illegal opcode and non-32-bit encoding
    inst_id = 32'hFFFF_FFFF;
    tick();
    check("ill_ff_illegal", {31'd0, illegal_ex}, 32'd1);
    check("ill_ff_rw", {31'd0, reg_write_ex}, 32'd0);
    check("ill_ff_ctrl", {28'd0, mem_read_ex, mem_write_ex, branch_ex, jump_ex}, 32'd0);
    inst_id = 32'h0050_0090;
    tick();
    check("ill_c_illegal", {31'd0, illegal_ex}, 32'd1);
    check("ill_c_rw", {31'd0, reg_write_ex}, 32'd0);

    // All-zero instruction is a legal bubble
    inst_id = 32'd0;
    tick();
    check("zero_illegal", {31'd0, illegal_ex}, 32'd0);
    check("zero_rw", {31'd0, reg_write_ex}, 32'd0);

    // clk_en=0 while stalled: everything holds
    inst_id = LW_X2_X1;
    pc_id   = 32'h0000_0300;
    tick();
    inst_id = ADD_X3_X2;
    clk_en  = 1'b0;
    #1;
    check("hold_stall_a", {31'd0, stall}, 32'd1);
    tick();
    check("hold_stall_b", {31'd0, stall}, 32'd1);
    check("hold_rd", {27'd0, rd_ex}, 32'd2);
    check("hold_mem_read", {31'd0, mem_read_ex}, 32'd1);
    check("hold_pc", pc_ex, 32'h0000_0300);

    // Reset mid-stream with clk_en=0 clears ID/EX and the register file
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_mem_read", {31'd0, mem_read_ex}, 32'd0);
    check("mrst_rd", {27'd0, rd_ex}, 32'd0);
    check("mrst_pc", pc_ex, 32'd0);
    check("mrst_stall", {31'd0, stall}, 32'd0);
    clk_en  = 1'b1;
    inst_id = ADDI_X4_X1;
    pc_id   = 32'h0000_0400;
    tick();
    check("mrst_x1_read", rs1_data_ex, 32'd0);
    check("mrst_addi_rd", {27'd0, rd_ex}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
